nios2os_led_seq: RTL and testbench
==================================

# nios2os_led_seq

LED pattern sequencer for the nios2os Qsys system. An Avalon-MM slave register file, written by the Nios II, holds up to four 4-bit LED patterns, a step period and a run/loop control. An Avalon-MM master port writes those patterns in order into the data register (address 0) of the LED PIO's s1 port, one pattern per step, so the LEDs animate without CPU involvement. An optional interrupt fires when a one-shot sequence completes.

## Interface
- PERIOD_W, 24, width of the step-period counter/register
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  slave word address
- chipselect  in  1  slave select
- write_n  in  1  slave write strobe, active low
- writedata  in  32  slave write data
- readdata  out  32  slave read data; combinational, zero wait states, unused bits read 0
- m_address  out  2  master address to LED PIO; always 0
- m_chipselect  out  1  master select
- m_write_n  out  1  master write strobe, active low
- m_writedata  out  32  {28'b0, pattern}
- m_waitrequest  in  1  stall from the interconnect; 0 for a zero-wait-state PIO
- irq  out  1  done & irq_en

## Operation
- Register map (word address):
  - 0 CTRL: bit0 run, bit1 loop, bit2 irq_en; read/write
  - 1 STATUS: bit0 busy (read-only), bit1 done (write 1 to clear), bits[5:4] current index (read-only)
  - 2 PERIOD: bits[PERIOD_W-1:0]; value 0 treated as 1
  - 3 LENGTH: bits[2:0]; 0 treated as 1, values >4 clamped to 4
  - 4..7 PATTERN[0..3]: bits[3:0]
- Slave write = chipselect & ~write_n; register updates on the same clock edge.
- FSM states IDLE, WRITE, WAIT; busy = (state != IDLE).
  - IDLE: master idle (m_chipselect 0, m_write_n 1). A CTRL write with run=1 → index=0, go WRITE.
  - WRITE: m_chipselect=1, m_write_n=0, m_writedata={28'b0, PATTERN[index]}, with PATTERN sampled on WRITE entry and held until accepted. The write is accepted in the cycle m_waitrequest=0; then cnt ← effective PERIOD and go WAIT.
  - WAIT: cnt decrements each cycle. At cnt==1, the step ends:
    - if index < LENGTH_eff-1: index+1, go WRITE.
    - else, if loop=1: index=0, go WRITE.
    - else: set done, clear run, go IDLE.
- Stop: a CTRL write with run=0 during WAIT → IDLE next cycle. During WRITE, the pending write completes (waitrequest honoured, never truncated), then IDLE. done is not set on a stop.
- A CTRL write with run=1 while busy updates loop/irq_en only; no restart and index is unchanged.
- A PATTERN write while running takes effect the next time that entry enters WRITE. PERIOD and LENGTH writes affect the next cnt load and the next end-of-step check.
- If done is set by the FSM and cleared by a W1C in the same cycle, set wins.
- irq is registered-level: irq = done & irq_en, deasserts when done is cleared or irq_en=0.

## Timing
- Reset: CTRL=0, STATUS=0, PERIOD=0, LENGTH=0, PATTERN[*]=0, state IDLE, cnt=0, m_chipselect=0, m_write_n=1, m_writedata=0, m_address=0, irq=0. Reset mid-write abandons the transfer immediately.
- Start latency: a CTRL run=1 write at edge T → m_chipselect high in cycle T+1.
- With m_waitrequest=0, successive write-accept cycles are PERIOD_eff+1 cycles apart.
- Each cycle of m_waitrequest=1 delays that step by one cycle; the master signals stay stable while stalled.
- One-shot done: set on the edge after the final WAIT cycle. irq is high in the same cycle that done reads 1.
- readdata reflects the register contents as of the current cycle (combinational from address).

## Test plan
- Reset then read all 8 addresses → all 0; m_chipselect=0, m_write_n=1, irq=0.
- PATTERN={1,2,4,8}, LENGTH=4, PERIOD=3, CTRL=0x5 (run, irq_en, no loop), waitrequest=0 → writes 1,2,4,8 at address 0 spaced 4 cycles apart; afterwards STATUS=0x32 (done, index 3), CTRL.run=0, irq=1; W1C STATUS bit1 → irq=0.
- Same setup with CTRL=0x3 (loop) → pattern 1,2,4,8,1,2,… continues with no gap at wrap; clear run mid-WAIT → no further writes, busy=0 next cycle, done=0.
- waitrequest held high 5 cycles on the second write → m_writedata=2 held stable with m_chipselect high throughout; spacing to the next write grows by 5; clear run during the stall → the write completes, then IDLE.
- LENGTH=0 and PERIOD=0 → single write of PATTERN[0], done after 2 cycles; LENGTH=7 behaves as 4.
- While running, write PATTERN[2]=0xF before index 2 is reached → 0xF is emitted at step 2; a CTRL run=1 rewrite mid-sequence → index is not reset.

Source files
------------

// File: rtl/nios2os_led_seq.sv
// nios2os_led_seq
//   LED pattern sequencer. A Nios II programs up to four 4-bit patterns, a
//   step period and run/loop/irq controls through an Avalon-MM slave; an
//   Avalon-MM master writes the patterns in turn into the LED PIO data
//   register, one pattern per step.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   address/chipselect/  slave register file (8 words, zero wait states,
//   write_n/writedata/   readdata is combinational from address)
//   readdata
//   m_address/m_chipselect/m_write_n/m_writedata/m_waitrequest
//                        master write port to the LED PIO s1
//   irq                  done & irq_en
module nios2os_led_seq #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [1:0]          m_address,
  output logic                m_chipselect,
  output logic                m_write_n,
  output logic [31:0]         m_writedata,
  input  logic                m_waitrequest,
  output logic                irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                state, state_d;

  logic                  run, loop, irq_en, done;
  logic [PERIOD_W-1:0]   period;
  logic [2:0]            length;
  logic [3:0]            pattern [4];
  logic [1:0]            index, idx_d;
  logic [PERIOD_W-1:0]   cnt, cnt_d;

  logic                  wr, ctrl_wr, status_wr, stop_wr;
  logic                  enter_write, set_done, clr_run, last_step;
  logic [PERIOD_W-1:0]   period_eff;
  logic [2:0]            len_eff;
  logic                  busy;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata[31:PERIOD_W];

  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr && (address == 3'd0);
  assign status_wr = wr && (address == 3'd1);
  assign stop_wr   = ctrl_wr & ~writedata[0];

  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
  assign len_eff    = (length == 3'd0) ? 3'd1 :
                      (length > 3'd4)  ? 3'd4 : length;
  // >= rather than == so a LENGTH shrunk below the current index still ends
  assign last_step  = ({1'b0, index} >= (len_eff - 3'd1));

  assign busy         = (state != S_IDLE);
  assign m_address    = '0;
  assign m_chipselect = (state == S_WRITE);
  assign m_write_n    = ~(state == S_WRITE);
  assign irq          = done & irq_en;

  always_comb begin
    state_d     = state;
    idx_d       = index;
    cnt_d       = cnt;
    enter_write = 1'b0;
    set_done    = 1'b0;
    clr_run     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctrl_wr && writedata[0]) begin
          state_d     = S_WRITE;
          idx_d       = 2'd0;
          enter_write = 1'b1;
        end
      end
      S_WRITE: begin
        // A stop requested while stalled is remembered in run=0 and only
        // acted on once the transfer has been accepted.
        if (!m_waitrequest) begin
          cnt_d   = period_eff;
          state_d = (stop_wr || !run) ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop_wr || !run) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - PERIOD_W'(1);
          if (cnt <= PERIOD_W'(1)) begin
            if (!last_step) begin
              idx_d       = index + 2'd1;
              state_d     = S_WRITE;
              enter_write = 1'b1;
            end else if (loop) begin
              idx_d       = 2'd0;
              state_d     = S_WRITE;
              enter_write = 1'b1;
            end else begin
              set_done = 1'b1;
              clr_run  = 1'b1;
              state_d  = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      index       <= '0;
      cnt         <= '0;
      m_writedata <= '0;
      run         <= 1'b0;
      loop        <= 1'b0;
      irq_en      <= 1'b0;
      done        <= 1'b0;
      period      <= '0;
      length      <= '0;
      for (int unsigned i = 0; i < 4; i++) pattern[i] <= '0;
    end else begin
      state <= state_d;
      index <= idx_d;
      cnt   <= cnt_d;
      if (enter_write) m_writedata <= {28'b0, pattern[idx_d]};

      if (ctrl_wr) begin
        run    <= writedata[0];
        loop   <= writedata[1];
        irq_en <= writedata[2];
      end
      if (clr_run) run <= 1'b0;

      // set beats a simultaneous write-1-to-clear
      if (status_wr && writedata[1]) done <= 1'b0;
      if (set_done) done <= 1'b1;

      if (wr && address == 3'd2) period <= writedata[PERIOD_W-1:0];
      if (wr && address == 3'd3) length <= writedata[2:0];
      if (wr && address[2])      pattern[address[1:0]] <= writedata[3:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = {29'b0, irq_en, loop, run};
      3'd1:    readdata = {26'b0, index, 2'b0, done, busy};
      3'd2:    readdata = {{(32-PERIOD_W){1'b0}}, period};
      3'd3:    readdata = {29'b0, length};
      default: readdata = {28'b0, pattern[address[1:0]]};
    endcase
  end

endmodule

// File: tb/tb_nios2os_led_seq.sv
`timescale 1ns/1ps
module tb_nios2os_led_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  int          cyc = 0;
  int          irq_cyc = 0;
  logic        irq_prev = 1'b0;
  int          wr_cyc;
  logic [31:0] wq_data [$];
  int          wq_cyc  [$];

  always #5 clk = ~clk;

  nios2os_led_seq #(.PERIOD_W(24)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .irq           (irq)
  );

  // Master-side monitor: records every accepted write and the irq rise cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m_chipselect && !m_write_n && !m_waitrequest) begin
      wq_data.push_back(m_writedata);
      wq_cyc.push_back(cyc + 1);
    end
    if (irq && !irq_prev) irq_cyc <= cyc + 1;
    irq_prev <= irq;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    wr_cyc = cyc;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(posedge clk); #1;
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k = 0;
    while (wq_data.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, wq_data.size(), n);
  endtask

  task automatic clear_q();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  // Waits for the master to enter a write while stalled; bounded.
  task automatic wait_cs(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_chipselect && k < 20);
    check(tag, m_chipselect, 1'b1);
  endtask

  task automatic chk_seq(input string tag, input logic [31:0] exp_d [4], input int n, input int sp0, input int sp);
    for (int i = 0; i < n; i++) begin
      if (i < wq_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), wq_data[i], exp_d[i]);
        if (i > 0)
          check($sformatf("%s_gap%0d", tag, i), wq_cyc[i] - wq_cyc[i-1], (i == 1) ? sp0 : sp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq_a [4];
    logic [31:0] seq_f [4];
    seq_a = '{32'h1, 32'h2, 32'h4, 32'h8};
    seq_f = '{32'h1, 32'h2, 32'hF, 32'h8};

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; m_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    for (int a = 0; a < 8; a++) rd_chk($sformatf("reset_reg%0d", a), 3'(a), 32'h0);
    check("reset_m_cs", m_chipselect, 1'b0);
    check("reset_m_wn", m_write_n, 1'b1);
    check("reset_irq", irq, 1'b0);
    check("reset_m_wd", m_writedata, 32'h0);

    // One-shot, 4 patterns, PERIOD=3
    bus_wr(3'd4, 32'h1); bus_wr(3'd5, 32'h2); bus_wr(3'd6, 32'h4); bus_wr(3'd7, 32'h8);
    bus_wr(3'd3, 32'd4); bus_wr(3'd2, 32'd3);
    rd_chk("rd_pattern2", 3'd6, 32'h4);
    rd_chk("rd_period", 3'd2, 32'd3);
    clear_q();
    bus_wr(3'd0, 32'h5);
    wait_writes(4, 40, "oneshot_count");
    check("start_latency", wq_cyc[0] - wr_cyc, 1);
    check("m_address", m_address, 2'd0);
    chk_seq("oneshot", seq_a, 4, 4, 4);
    repeat (6) @(negedge clk);
    check("oneshot_irq_time", irq_cyc - wq_cyc[3], 4);
    rd_chk("oneshot_status", 3'd1, 32'h32);
    rd_chk("oneshot_ctrl", 3'd0, 32'h4);
    check("oneshot_irq", irq, 1'b1);
    check("oneshot_idle_cs", m_chipselect, 1'b0);
    bus_wr(3'd1, 32'h2);
    check("w1c_irq", irq, 1'b0);
    rd_chk("w1c_status", 3'd1, 32'h30);

    // Loop, then stop during WAIT
    clear_q();
    bus_wr(3'd0, 32'h3);
    wait_writes(6, 60, "loop_count");
    bus_wr(3'd0, 32'h2);
    address = 3'd1; #1;
    check("loop_stop_status", readdata, 32'h10);
    chk_seq("loop", seq_a, 4, 4, 4);
    if (wq_data.size() >= 6) begin
      check("loop_wrap_data", wq_data[4], 32'h1);
      check("loop_wrap_gap", wq_cyc[4] - wq_cyc[3], 4);
      check("loop_data5", wq_data[5], 32'h2);
    end
    repeat (20) @(negedge clk);
    check("loop_no_more", wq_data.size(), 6);
    check("loop_irq", irq, 1'b0);

    // Stall of 5 cycles on the second write
    clear_q();
    bus_wr(3'd0, 32'h1);
    wait_writes(1, 20, "stall_first");
    @(posedge clk); #1 m_waitrequest = 1'b1;
    wait_cs("stall_start");
    check("stall_wd0", m_writedata, 32'h2);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_cs%0d", i), m_chipselect, 1'b1);
      check($sformatf("stall_wd%0d", i), m_writedata, 32'h2);
      check($sformatf("stall_wn%0d", i), m_write_n, 1'b0);
    end
    @(posedge clk); #1 m_waitrequest = 1'b0;
    wait_writes(4, 60, "stall_count");
    chk_seq("stall", seq_a, 4, 9, 4);
    repeat (8) @(negedge clk);
    rd_chk("stall_status", 3'd1, 32'h32);
    bus_wr(3'd1, 32'h2);

    // Stop requested while the second write is stalled
    clear_q();
    bus_wr(3'd0, 32'h1);
    wait_writes(1, 20, "stopstall_first");
    @(posedge clk); #1 m_waitrequest = 1'b1;
    wait_cs("stopstall_start");
    bus_wr(3'd0, 32'h0);
    @(negedge clk);
    check("stopstall_hold_cs", m_chipselect, 1'b1);
    check("stopstall_hold_wd", m_writedata, 32'h2);
    @(posedge clk); #1 m_waitrequest = 1'b0;
    repeat (10) @(negedge clk);
    check("stopstall_count", wq_data.size(), 2);
    if (wq_data.size() >= 2) check("stopstall_data", wq_data[1], 32'h2);
    check("stopstall_cs", m_chipselect, 1'b0);
    rd_chk("stopstall_status", 3'd1, 32'h10);

    // LENGTH=0, PERIOD=0
    bus_wr(3'd3, 32'd0); bus_wr(3'd2, 32'd0);
    clear_q();
    bus_wr(3'd0, 32'h5);
    wait_writes(1, 20, "min_first");
    repeat (8) @(negedge clk);
    check("min_count", wq_data.size(), 1);
    check("min_data", wq_data[0], 32'h1);
    check("min_done_time", irq_cyc - wq_cyc[0], 2);
    rd_chk("min_status", 3'd1, 32'h02);
    bus_wr(3'd1, 32'h2);

    // LENGTH=7 clamps to 4
    bus_wr(3'd3, 32'd7);
    clear_q();
    bus_wr(3'd0, 32'h1);
    wait_writes(4, 40, "len7_count");
    chk_seq("len7", seq_a, 4, 2, 2);
    repeat (8) @(negedge clk);
    check("len7_no_more", wq_data.size(), 4);
    rd_chk("len7_status", 3'd1, 32'h32);
    bus_wr(3'd1, 32'h2);

    // PATTERN update and CTRL rewrite while running
    bus_wr(3'd3, 32'd4); bus_wr(3'd2, 32'd3);
    clear_q();
    bus_wr(3'd0, 32'h1);
    wait_writes(1, 20, "live_first");
    bus_wr(3'd6, 32'hF);
    bus_wr(3'd0, 32'h1);
    wait_writes(4, 60, "live_count");
    chk_seq("live", seq_f, 4, 4, 4);
    repeat (8) @(negedge clk);
    check("live_no_more", wq_data.size(), 4);
    rd_chk("live_status", 3'd1, 32'h32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
